// File: rtl/video_stream_arbiter_pkg.sv
// rtl/video_stream_arbiter_pkg.sv - shared encodings for the video stream arbiter
//
// Purpose: arbiter FSM state encoding, packet header codes, source-selection
// mode encodings and the small decode/selection helpers used by the top.
// Ports: none (package).

package video_stream_arbiter_pkg;

    // Arbiter states. CTRL_GAP is the window between a control packet and
    // the video packet of the same frame; the source stays locked there.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CTRL     = 3'd1,
        ST_CTRL_GAP = 3'd2,
        ST_VIDEO    = 3'd3,
        ST_USER     = 3'd4
    } state_t;

    // Packet type, decoded from data[3:0] on a start-of-packet beat.
    typedef enum logic [1:0] {
        PKT_CTRL  = 2'd0,
        PKT_VIDEO = 2'd1,
        PKT_USER  = 2'd2
    } pkt_t;

    localparam logic [3:0] HDR_CTRL  = 4'hF;
    localparam logic [3:0] HDR_VIDEO = 4'h0;

    // Source-selection modes presented on the mode input.
    localparam logic [1:0] MODE_SRC0 = 2'd0;  // source 0 only
    localparam logic [1:0] MODE_SRC1 = 2'd1;  // source 1 only
    localparam logic [1:0] MODE_ALT  = 2'd2;  // alternate per frame
    localparam logic [1:0] MODE_HOLD = 2'd3;  // stay with last frame source

    function automatic pkt_t decode_pkt(input logic [3:0] hdr);
        pkt_t t;
        if (hdr == HDR_CTRL) begin
            t = PKT_CTRL;
        end else if (hdr == HDR_VIDEO) begin
            t = PKT_VIDEO;
        end else begin
            t = PKT_USER;
        end
        return t;
    endfunction

    // Source to offer the next frame to, given the mode and the source that
    // delivered the previous frame.
    function automatic logic next_candidate(input logic [1:0] mode, input logic last_src);
        logic cand;
        case (mode)
            MODE_SRC0: cand = 1'b0;
            MODE_SRC1: cand = 1'b1;
            MODE_ALT:  cand = ~last_src;
            default:   cand = last_src;
        endcase
        return cand;
    endfunction

endpackage

// File: rtl/video_stream_arbiter.sv
// rtl/video_stream_arbiter.sv - frame-aware 2:1 arbiter for ready-latency-1 video streams
//
// Purpose: merges two packetised video sources onto one sink without ever
// interleaving packets inside a frame. A frame is a control packet (header
// 15), optional user packets, and a video packet (header 0); the source is
// locked from the first sop until the video eop. The next source is chosen
// at frame end from mode; in alternate mode an IDLE timeout skips a silent
// candidate.
//
// Ports:
//   clk, rst                 sole clock, asynchronous active-high reset
//   din0_* / din1_*          source streams: valid, data, sop, eop, empty in;
//                            ready out (ready latency 1)
//   dout_*                   sink stream: ready in; valid, data, sop, eop,
//                            empty out (combinational from the owning source)
//   mode                     0 src0 only, 1 src1 only, 2 alternate, 3 hold
//   cur_src                  locked source outside IDLE, candidate in IDLE
//   frame_done               one-cycle pulse the cycle after a frame's video eop

module video_stream_arbiter
    import video_stream_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int IDLE_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  din0_valid,
    input  logic [DATA_WIDTH-1:0] din0_data,
    input  logic                  din0_sop,
    input  logic                  din0_eop,
    input  logic [1:0]            din0_empty,
    output logic                  din0_ready,

    input  logic                  din1_valid,
    input  logic [DATA_WIDTH-1:0] din1_data,
    input  logic                  din1_sop,
    input  logic                  din1_eop,
    input  logic [1:0]            din1_empty,
    output logic                  din1_ready,

    input  logic                  dout_ready,
    output logic                  dout_valid,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_sop,
    output logic                  dout_eop,
    output logic [1:0]            dout_empty,

    input  logic [1:0]            mode,
    output logic                  cur_src,
    output logic                  frame_done
);

    localparam int CNT_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              owner_q, owner_d;          // source given ready last cycle
    logic              grant_q, grant_d;          // that source really had ready
    logic              lock_src_q, lock_src_d;
    logic              last_src_q, last_src_d;    // source of the last full frame
    logic              cand_q, cand_d;
    logic              fresh_q, fresh_d;          // first cycle out of reset
    logic              user_ret_idle_q, user_ret_idle_d;
    logic              frame_done_q, frame_done_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;

    logic                  sel_valid;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_sop;
    logic                  sel_eop;
    logic [1:0]            sel_empty;

    logic  beat;
    logic  drop;
    logic  frame_end;
    logic  cand_base;
    logic  target;
    pkt_t  beat_type;

    // Datapath: 2:1 mux on the registered owner, zero latency.
    always_comb begin
        if (owner_q) begin
            sel_valid = din1_valid;
            sel_data  = din1_data;
            sel_sop   = din1_sop;
            sel_eop   = din1_eop;
            sel_empty = din1_empty;
        end else begin
            sel_valid = din0_valid;
            sel_data  = din0_data;
            sel_sop   = din0_sop;
            sel_eop   = din0_eop;
            sel_empty = din0_empty;
        end
    end

    // Gating with grant_q discards anything a source presents without having
    // been given ready, e.g. the first cycle after reset.
    assign beat      = grant_q & sel_valid;
    assign beat_type = decode_pkt(sel_data[3:0]);

    // Out of reset the candidate is derived from mode directly; afterwards it
    // is the registered value computed at frame end.
    assign cand_base = fresh_q ? next_candidate(mode, last_src_q) : cand_q;

    always_comb begin
        state_d         = state_q;
        lock_src_d      = lock_src_q;
        last_src_d      = last_src_q;
        user_ret_idle_d = user_ret_idle_q;
        frame_end       = 1'b0;
        drop            = 1'b0;

        if (beat) begin
            case (state_q)
                ST_IDLE: begin
                    if (sel_sop) begin
                        lock_src_d = owner_q;
                        case (beat_type)
                            PKT_CTRL:  state_d = sel_eop ? ST_CTRL_GAP : ST_CTRL;
                            PKT_VIDEO: begin
                                if (sel_eop) begin
                                    state_d   = ST_IDLE;
                                    frame_end = 1'b1;
                                end else begin
                                    state_d = ST_VIDEO;
                                end
                            end
                            default: begin
                                // Stray user packet outside a frame: forward
                                // it, then fall back to IDLE with no pulse.
                                state_d         = sel_eop ? ST_IDLE : ST_USER;
                                user_ret_idle_d = 1'b1;
                            end
                        endcase
                    end else begin
                        // Tail of a packet we never saw start (e.g. after reset).
                        drop = 1'b1;
                    end
                end
                ST_CTRL: begin
                    if (sel_eop) state_d = ST_CTRL_GAP;
                end
                ST_CTRL_GAP: begin
                    if (sel_sop) begin
                        case (beat_type)
                            PKT_CTRL:  state_d = sel_eop ? ST_CTRL_GAP : ST_CTRL;
                            PKT_VIDEO: begin
                                if (sel_eop) begin
                                    state_d   = ST_IDLE;
                                    frame_end = 1'b1;
                                end else begin
                                    state_d = ST_VIDEO;
                                end
                            end
                            default: begin
                                state_d         = sel_eop ? ST_CTRL_GAP : ST_USER;
                                user_ret_idle_d = 1'b0;
                            end
                        endcase
                    end
                end
                ST_VIDEO: begin
                    if (sel_eop) begin
                        state_d   = ST_IDLE;
                        frame_end = 1'b1;
                    end
                end
                ST_USER: begin
                    if (sel_eop) state_d = user_ret_idle_q ? ST_IDLE : ST_CTRL_GAP;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (frame_end) last_src_d = lock_src_d;
    end

    // Candidate selection and IDLE timeout.
    always_comb begin
        cand_d     = cand_base;
        fresh_d    = 1'b0;
        idle_cnt_d = idle_cnt_q;

        if (frame_end) cand_d = next_candidate(mode, lock_src_d);

        if (beat || (state_q != ST_IDLE && state_d == ST_IDLE)) begin
            idle_cnt_d = '0;
        end else if (state_q == ST_IDLE && dout_ready) begin
            if (idle_cnt_q == CNT_MAX) begin
                // Only alternate mode may skip a silent candidate; other
                // modes just sit at the limit.
                if (mode == MODE_ALT) begin
                    cand_d     = ~cand_base;
                    idle_cnt_d = '0;
                end
            end else begin
                idle_cnt_d = idle_cnt_q + CNT_W'(1);
            end
        end
    end

    // Target looks at the next state so that on a frame-ending beat the
    // released source already loses ready in that same cycle.
    assign target = (state_d == ST_IDLE) ? cand_d : lock_src_d;

    always_comb begin
        owner_d      = dout_ready ? target : owner_q;
        grant_d      = dout_ready;
        frame_done_d = frame_end;
    end

    assign din0_ready = ~rst & dout_ready & (target == 1'b0);
    assign din1_ready = ~rst & dout_ready & (target == 1'b1);

    assign dout_valid = ~rst & beat & ~drop;
    assign dout_data  = sel_data;
    assign dout_sop   = sel_sop;
    assign dout_eop   = sel_eop;
    assign dout_empty = sel_empty;

    assign cur_src    = (state_q == ST_IDLE) ? cand_base : lock_src_q;
    assign frame_done = frame_done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            owner_q         <= 1'b0;
            grant_q         <= 1'b0;
            lock_src_q      <= 1'b0;
            last_src_q      <= 1'b1;
            cand_q          <= 1'b0;
            fresh_q         <= 1'b1;
            user_ret_idle_q <= 1'b0;
            frame_done_q    <= 1'b0;
            idle_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            grant_q         <= grant_d;
            lock_src_q      <= lock_src_d;
            last_src_q      <= last_src_d;
            cand_q          <= cand_d;
            fresh_q         <= fresh_d;
            user_ret_idle_q <= user_ret_idle_d;
            frame_done_q    <= frame_done_d;
            idle_cnt_q      <= idle_cnt_d;
        end
    end

endmodule

// File: tb/tb_video_stream_arbiter.sv
// tb/tb_video_stream_arbiter.sv - self-checking bench for video_stream_arbiter

module tb_video_stream_arbiter;

    localparam int DW = 24;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          din0_valid, din0_sop, din0_eop, din0_ready;
    logic [DW-1:0] din0_data;
    logic [1:0]    din0_empty;
    logic          din1_valid, din1_sop, din1_eop, din1_ready;
    logic [DW-1:0] din1_data;
    logic [1:0]    din1_empty;
    logic          dout_ready, dout_valid, dout_sop, dout_eop;
    logic [DW-1:0] dout_data;
    logic [1:0]    dout_empty;
    logic [1:0]    mode;
    logic          cur_src, frame_done;

    always #5 clk = ~clk;

    video_stream_arbiter #(.DATA_WIDTH(DW), .IDLE_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .din0_valid(din0_valid), .din0_data(din0_data), .din0_sop(din0_sop),
        .din0_eop(din0_eop), .din0_empty(din0_empty), .din0_ready(din0_ready),
        .din1_valid(din1_valid), .din1_data(din1_data), .din1_sop(din1_sop),
        .din1_eop(din1_eop), .din1_empty(din1_empty), .din1_ready(din1_ready),
        .dout_ready(dout_ready), .dout_valid(dout_valid), .dout_data(dout_data),
        .dout_sop(dout_sop), .dout_eop(dout_eop), .dout_empty(dout_empty),
        .mode(mode), .cur_src(cur_src), .frame_done(frame_done)
    );

    // beat = {sop, eop, empty[1:0], data[23:0]}; data[23] carries the source id.
    typedef logic [27:0] beat_t;
    beat_t q0[$], q1[$], exp_q[$], out_q[$];

    int         n_cmp = 0;
    int         n_fail = 0;
    int         seq = 0;
    int         fd_cnt;
    logic [1:0] rdy_prev;
    logic       prev_dr;
    logic       rand_rdy;
    logic       force_v1;
    logic       din1_seen;
    logic       cur_s;

    typedef struct {
        logic [1:0] mode;
        logic       rdy;
        logic       v0, s0, e0;
        logic [3:0] h0;
        logic       v1, s1, e1;
        logic [3:0] h1;
        logic [6:0] exp;   // {din0_ready, din1_ready, dout_valid, sop, eop, cur_src, frame_done}
    } vec_t;
    vec_t vt[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        beat_t b;
        if (rdy_prev[0] && q0.size() > 0) begin
            b = q0.pop_front();
            din0_valid = 1'b1;
            {din0_sop, din0_eop, din0_empty, din0_data} = b;
        end else begin
            din0_valid = 1'b0; din0_sop = 1'b0; din0_eop = 1'b0;
        end
        if (force_v1) begin
            din1_valid = 1'b1; din1_sop = 1'b0; din1_eop = 1'b0;
            din1_data = 24'h80abcd; din1_empty = 2'd0;
        end else if (rdy_prev[1] && q1.size() > 0) begin
            b = q1.pop_front();
            din1_valid = 1'b1;
            {din1_sop, din1_eop, din1_empty, din1_data} = b;
        end else begin
            din1_valid = 1'b0; din1_sop = 1'b0; din1_eop = 1'b0;
        end
        dout_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (dout_valid) begin
            out_q.push_back({dout_sop, dout_eop, dout_empty, dout_data});
            check("valid_after_ready_low", prev_dr, 1);
        end
        check("one_ready", din0_ready & din1_ready, 0);
        if (rst) check("reset_quiet", {din0_ready, din1_ready, dout_valid}, 0);
        if (din1_ready) din1_seen = 1'b1;
        if (frame_done) fd_cnt++;
        cur_s    = cur_src;
        rdy_prev = {din1_ready, din0_ready};
        prev_dr  = dout_ready;
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input logic [1:0] m);
        rst = 1'b1; mode = m; dout_ready = 1'b1;
        din0_valid = 0; din0_sop = 0; din0_eop = 0; din0_data = '0; din0_empty = 0;
        din1_valid = 0; din1_sop = 0; din1_eop = 0; din1_data = '0; din1_empty = 0;
        q0.delete(); q1.delete(); exp_q.delete(); out_q.delete();
        rdy_prev = 2'b00; prev_dr = 1'b0; fd_cnt = 0; din1_seen = 1'b0;
        force_v1 = 1'b0; rand_rdy = 1'b0;
        @(negedge clk);
        check("reset_outputs", {din0_ready, din1_ready, dout_valid, frame_done}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic push_pkt(input int src, input logic [3:0] hdr, input int len, input bit to_exp);
        for (int i = 0; i < len; i++) begin
            beat_t      b;
            logic [23:0] d;
            d = {src[0], seq[18:0], (i == 0) ? hdr : 4'ha};
            b = {(i == 0), (i == len - 1), (i == len - 1) ? 2'd2 : 2'd0, d};
            seq++;
            if (src == 0) q0.push_back(b); else q1.push_back(b);
            if (to_exp) exp_q.push_back(b);
        end
    endtask

    task automatic drain(input int max);
        int c = 0;
        while ((q0.size() > 0 || q1.size() > 0) && c < max) begin
            tick();
            c++;
        end
        check("drain_in_time", c < max, 1);
        repeat (4) tick();
    endtask

    task automatic compare_out(input string name);
        int n;
        check({name, "_count"}, out_q.size(), exp_q.size());
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check(name, out_q[i], exp_q[i]);
        out_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int k;
        logic [6:0] act;

        //            mode  rdy v0 s0 e0 h0    v1 s1 e1 h1    exp
        vt[0]  = '{2'd0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 7'b1000000}; // idle after reset
        vt[1]  = '{2'd0, 1, 1, 0, 0, 4'ha, 0, 0, 0, 4'h0, 7'b1000000}; // non-sop dropped
        vt[2]  = '{2'd0, 1, 1, 1, 0, 4'hf, 0, 0, 0, 4'h0, 7'b1011000}; // ctrl sop
        vt[3]  = '{2'd0, 1, 1, 0, 1, 4'ha, 0, 0, 0, 4'h0, 7'b1010100}; // ctrl eop
        vt[4]  = '{2'd0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 7'b0000000}; // sink stall
        vt[5]  = '{2'd0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 7'b1000000}; // gap
        vt[6]  = '{2'd0, 1, 1, 1, 1, 4'h0, 0, 0, 0, 4'h0, 7'b1011100}; // 1-beat video
        vt[7]  = '{2'd0, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 7'b1000001}; // frame_done
        vt[8]  = '{2'd1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 7'b1000000}; // mode change waits
        vt[9]  = '{2'd1, 1, 1, 1, 1, 4'h0, 0, 0, 0, 4'h0, 7'b0111100}; // frame end -> src1
        vt[10] = '{2'd1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 7'b0100011};
        vt[11] = '{2'd1, 1, 0, 0, 0, 4'h0, 1, 1, 0, 4'h5, 7'b0111010}; // user sop in idle
        vt[12] = '{2'd1, 1, 0, 0, 0, 4'h0, 1, 0, 1, 4'ha, 7'b0110110}; // user eop
        vt[13] = '{2'd1, 1, 0, 0, 0, 4'h0, 0, 0, 0, 4'h0, 7'b0100010}; // no frame_done

        rst = 1'b1;
        @(posedge clk); #1;

        do_reset(2'd0);
        for (int i = 0; i < 14; i++) begin
            mode       = vt[i].mode;
            dout_ready = vt[i].rdy;
            din0_valid = vt[i].v0; din0_sop = vt[i].s0; din0_eop = vt[i].e0;
            din0_data  = {20'h00000, vt[i].h0}; din0_empty = 2'd0;
            din1_valid = vt[i].v1; din1_sop = vt[i].s1; din1_eop = vt[i].e1;
            din1_data  = {20'h80000, vt[i].h1}; din1_empty = 2'd0;
            @(negedge clk);
            act = {din0_ready, din1_ready, dout_valid, dout_valid & dout_sop,
                   dout_valid & dout_eop, cur_src, frame_done};
            check($sformatf("vec%0d", i), act, vt[i].exp);
            @(posedge clk); #1;
        end

        // Alternating frames, both sources saturated.
        do_reset(2'd2);
        push_pkt(0, 4'hf, 3, 1); push_pkt(0, 4'h0, 8, 1);
        push_pkt(1, 4'hf, 3, 1); push_pkt(1, 4'h0, 8, 1);
        push_pkt(0, 4'hf, 3, 1); push_pkt(0, 4'h0, 8, 1);
        push_pkt(1, 4'hf, 3, 1); push_pkt(1, 4'h0, 8, 1);
        drain(2000);
        compare_out("alt");
        check("alt_frame_done", fd_cnt, 4);

        // Mode 0 with source 1 holding valid high: source 1 never granted.
        do_reset(2'd0);
        force_v1 = 1'b1;
        push_pkt(0, 4'hf, 3, 1); push_pkt(0, 4'h0, 6, 1);
        push_pkt(0, 4'hf, 2, 1); push_pkt(0, 4'h0, 5, 1);
        drain(2000);
        force_v1 = 1'b0;
        compare_out("src0_only");
        check("src1_never_ready", din1_seen, 0);
        check("src0_frame_done", fd_cnt, 2);

        // User packet between ctrl and video stays with the locked source.
        do_reset(2'd2);
        push_pkt(0, 4'hf, 3, 1); push_pkt(0, 4'h5, 4, 1); push_pkt(0, 4'h0, 6, 1);
        push_pkt(1, 4'hf, 2, 1); push_pkt(1, 4'h0, 5, 1);
        drain(2000);
        compare_out("user_gap");
        check("user_frame_done", fd_cnt, 2);

        // Alternate mode with a silent source 1: timeout returns to source 0.
        do_reset(2'd2);
        push_pkt(0, 4'hf, 2, 1); push_pkt(0, 4'h0, 4, 1);
        push_pkt(0, 4'hf, 2, 1); push_pkt(0, 4'h0, 4, 1);
        c = 0;
        while (fd_cnt == 0 && c < 200) begin tick(); c++; end
        check("timeout_first_frame", c < 200, 1);
        check("timeout_cand_after_frame", cur_s, 1);
        k = 0;
        while (cur_s != 1'b0 && k < 100) begin tick(); k++; end
        check("timeout_cycles", k, 16);
        drain(500);
        compare_out("timeout");
        check("timeout_frame_done", fd_cnt, 2);

        // Random sink backpressure.
        do_reset(2'd0);
        rand_rdy = 1'b1;
        push_pkt(0, 4'hf, 3, 1); push_pkt(0, 4'h0, 12, 1);
        push_pkt(0, 4'hf, 3, 1); push_pkt(0, 4'h0, 12, 1);
        drain(3000);
        rand_rdy = 1'b0;
        compare_out("backpressure");
        check("bp_frame_done", fd_cnt, 2);

        // Reset in the middle of a video packet.
        do_reset(2'd0);
        push_pkt(0, 4'hf, 2, 0); push_pkt(0, 4'h0, 10, 0);
        push_pkt(0, 4'hf, 2, 1); push_pkt(0, 4'h0, 4, 1);
        c = 0;
        while (out_q.size() < 5 && c < 200) begin tick(); c++; end
        check("midvideo_reached", c < 200, 1);
        rst = 1'b1;
        #1;
        check("reset_async_outputs", {din0_ready, din1_ready, dout_valid, frame_done}, 0);
        tick();
        tick();
        rst = 1'b0;
        out_q.delete();
        drain(500);
        if (out_q.size() > 0) check("post_reset_first_beat", {out_q[0][27], out_q[0][23]}, 2'b10);
        compare_out("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
